// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: issues req/ack reads to instruction
// memory, delivers fetched words to IF/ID, and handles stall, redirect and misaligned PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PCResult,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        Fault,
  output logic [1:0]  debug_state
);

  // Memory handshake: IMemReq rises with IMemAddr and both hold steady until the
  // cycle IMemAck is seen; an ack while IMemReq is low means nothing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] instruction, instr_next;
  logic [31:0] instr_pc, instr_pc_next;
  logic        instr_valid, valid_next;
  logic        fault, fault_next;
  logic        deliver;
  logic [31:0] deliver_addr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      req_addr    <= 32'h0;
      instruction <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      instruction <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
      fault       <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    instr_next    = instruction;
    instr_pc_next = instr_pc;
    valid_next    = 1'b0;
    fault_next    = fault;
    IMemReq       = 1'b0;
    IMemAddr      = pc;
    deliver       = 1'b0;
    deliver_addr  = pc;

    case (state)
      ST_IDLE: begin
        IMemReq  = !Stall && !Redirect && (pc[1:0] == 2'b00);
        IMemAddr = pc;
        if (Redirect) begin
          pc_next = RedirectTarget;
        end else if (pc[1:0] != 2'b00) begin
          state_next = ST_FAULT;
          fault_next = 1'b1;
        end else if (Stall) begin
          state_next = ST_IDLE;
        end else if (IMemAck) begin
          // Zero-wait memory: request and delivery in the same cycle.
          deliver      = 1'b1;
          deliver_addr = pc;
        end else begin
          req_addr_next = pc;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        IMemReq  = 1'b1;
        IMemAddr = req_addr;
        if (Redirect) begin
          pc_next    = RedirectTarget;
          state_next = IMemAck ? ST_IDLE : ST_DROP;
        end else if (IMemAck) begin
          deliver      = 1'b1;
          deliver_addr = req_addr;
          state_next   = ST_IDLE;
        end
      end
      ST_DROP: begin
        // The outstanding response belongs to the old path; wait it out and discard it.
        IMemReq  = 1'b1;
        IMemAddr = req_addr;
        if (Redirect) pc_next = RedirectTarget;
        if (IMemAck) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase

    if (deliver) begin
      valid_next    = 1'b1;
      instr_next    = IMemData;
      instr_pc_next = deliver_addr;
      pc_next       = deliver_addr + 32'd4;
    end
  end

  assign PCResult    = pc;
  assign InstrValid  = instr_valid;
  assign Instruction = instruction;
  assign InstrPC     = instr_pc;
  assign Fault       = fault;
  assign debug_state = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: zero-wait fetch, delayed ack with stall, redirect
// drop cases, misaligned-PC fault, PC wrap and mid-request reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc_result;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fault;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk            (clk),
    .Reset          (reset),
    .Stall          (stall),
    .Redirect       (redirect),
    .RedirectTarget (redirect_target),
    .IMemReq        (imem_req),
    .IMemAddr       (imem_addr),
    .IMemAck        (imem_ack),
    .IMemData       (imem_data),
    .PCResult       (pc_result),
    .InstrValid     (instr_valid),
    .Instruction    (instruction),
    .InstrPC        (instr_pc),
    .Fault          (fault),
    .debug_state    (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_data = 32'h0;
    tick();
    tick();
    checks++; if (pc_result !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_result, 32'h0); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instruction !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h/%h exp=0/0", instruction, instr_pc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (debug_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", debug_state, S_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_data;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_data  = 32'hA000_0000 | (i * 4);
      imem_data = exp_data;
      settle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== i * 4) begin errors++; $display("FAIL zw_req[%0d] got=%b/%h exp=1/%h", i, imem_req, imem_addr, i * 4); end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== i * 4 || instruction !== exp_data) begin
        errors++; $display("FAIL zw_deliver[%0d] got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr_pc, instruction, i * 4, exp_data);
      end
    end
    checks++; if (pc_result !== 32'hC) begin errors++; $display("FAIL zw_pc got=%h exp=%h", pc_result, 32'hC); end
    imem_ack = 1'b0;
    stall = 1'b1;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_stall_req got=%b exp=0", imem_req); end
    tick();
    checks++; if (instr_valid !== 1'b0 || pc_result !== 32'hC) begin errors++; $display("FAIL zw_stall_hold got=%b/%h exp=0/%h", instr_valid, pc_result, 32'hC); end
  endtask

  task automatic test_ack_delay();
    stall = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL ad_issue got=%b/%h exp=1/%h", imem_req, imem_addr, 32'hC); end
    tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin
        errors++; $display("FAIL ad_hold[%0d] got=%b/%h/%b exp=1/%h/0", k, imem_req, imem_addr, instr_valid, 32'hC);
      end
      tick();
    end
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL ad_ack_req got=%b/%h exp=1/%h", imem_req, imem_addr, 32'hC); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'hDEAD_BEEF || instr_pc !== 32'hC || pc_result !== 32'h10) begin
      errors++; $display("FAIL ad_deliver got=%b/%h/%h/%h exp=1/deadbeef/c/10", instr_valid, instruction, instr_pc, pc_result);
    end
    imem_ack = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ad_stall_noreq got=%b exp=0", imem_req); end
    imem_ack = 1'b1; imem_data = 32'h5555_5555;
    tick();
    checks++; if (instr_valid !== 1'b0 || pc_result !== 32'h10 || instruction !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ad_ignored_ack got=%b/%h/%h exp=0/10/deadbeef", instr_valid, pc_result, instruction);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_busy();
    stall = 1'b0;
    tick();
    checks++; if (debug_state !== S_BUSY) begin errors++; $display("FAIL rb_busy got=%0d exp=%0d", debug_state, S_BUSY); end
    redirect = 1'b1; redirect_target = 32'h100;
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (debug_state !== S_DROP || pc_result !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL rb_drop got=%0d/%h/%b/%h exp=2/100/1/10", debug_state, pc_result, imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b1; imem_data = 32'hBAD0_0001;
    tick();
    checks++; if (instr_valid !== 1'b0 || instruction !== 32'hDEAD_BEEF || debug_state !== S_IDLE) begin
      errors++; $display("FAIL rb_discard got=%b/%h/%0d exp=0/deadbeef/0", instr_valid, instruction, debug_state);
    end
    imem_ack = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rb_newaddr got=%b/%h exp=1/100", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'h0000_1234;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== 32'h1234 || pc_result !== 32'h104) begin
      errors++; $display("FAIL rb_deliver got=%b/%h/%h/%h exp=1/100/1234/104", instr_valid, instr_pc, instruction, pc_result);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_ack_same();
    tick();
    redirect = 1'b1; redirect_target = 32'h200; imem_ack = 1'b1; imem_data = 32'hBAD0_0002;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || pc_result !== 32'h200 || instr_pc !== 32'h100 || debug_state !== S_IDLE) begin
      errors++; $display("FAIL ra_same got=%b/%h/%h/%0d exp=0/200/100/0", instr_valid, pc_result, instr_pc, debug_state);
    end
    tick();
    redirect = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_target = 32'h400; imem_ack = 1'b1; imem_data = 32'hBAD0_0003;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || pc_result !== 32'h400 || debug_state !== S_IDLE) begin
      errors++; $display("FAIL ra_last_wins got=%b/%h/%0d exp=0/400/0", instr_valid, pc_result, debug_state);
    end
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_target = 32'h102;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ft_redirect_noreq got=%b exp=0", imem_req); end
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (pc_result !== 32'h102 || imem_req !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL ft_loaded got=%h/%b/%b exp=102/0/0", pc_result, imem_req, fault);
    end
    tick();
    redirect = 1'b1; redirect_target = 32'h0; imem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || pc_result !== 32'h102 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL ft_halt[%0d] got=%b/%b/%h/%b exp=1/0/102/0", k, fault, imem_req, pc_result, instr_valid);
      end
      tick();
    end
    redirect = 1'b0; imem_ack = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pc_result !== 32'h0 || fault !== 1'b0 || debug_state !== S_IDLE) begin
      errors++; $display("FAIL ft_reset got=%h/%b/%0d exp=0/0/0", pc_result, fault, debug_state);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; imem_ack = 1'b1; imem_data = 32'hCAFE_F00D;
    settle();
    checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wr_addr got=%h/%b exp=fffffffc/1", imem_addr, imem_req); end
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || pc_result !== 32'h0) begin
      errors++; $display("FAIL wr_wrap got=%b/%h/%h exp=1/fffffffc/0", instr_valid, instr_pc, pc_result);
    end
    redirect = 1'b1; redirect_target = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (debug_state !== S_BUSY || imem_addr !== 32'h40) begin errors++; $display("FAIL wr_busy got=%0d/%h exp=1/40", debug_state, imem_addr); end
    reset = 1'b1;
    tick();
    checks++; if (debug_state !== S_IDLE || pc_result !== 32'h0 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 32'h0 || fault !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wr_reset got=%0d/%h/%b/%h/%h/%b/%h exp=0/0/0/0/0/0/0", debug_state, pc_result, instr_valid, instruction, instr_pc, fault, imem_addr);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_redirect_busy();
    test_redirect_ack_same();
    test_fault();
    test_wrap_and_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
